perip_bridge: RTL and testbench

//  Memory-mapped bridge on the CPU data port (perip_* bus) in front of DRAM and board I/O.

---
 rtl/perip_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_perip_bridge.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perip_bridge.sv
// perip_bridge: memory-mapped bridge on the CPU data port.
//   Decodes every access on the perip_* bus to DRAM or to one of four
//   board I/O registers, runs the 7-segment scan and the millisecond timer.
//   Load data is combinational so the CPU sees it in the same (MEM) cycle.
//
// Address map:
//   DRAM 0x8010_0000 .. +2^(DRAM_AW+2)-1   SW  0x8020_0000   SEG 0x8020_0020
//   LED  0x8020_0040                        CNT 0x8020_0050   (others: read 0, write ignored)
//
// Ports:
//   cpu_clk, cpu_rst                 clock (rising edge), asynchronous active-high reset
//   perip_addr/wen/mask/wdata        CPU byte address, store strobe, size, LSB-aligned data
//   perip_rdata                      combinational load data (raw 32-bit word)
//   dram_addr/wen/mask/wdata/rdata   DRAM word interface
//   sw                               asynchronous board switches
//   led                              LED register
//   seg_an, seg_code                 active-low digit enable and segments {dp,g..a}
//
// Configuration macro: PERIP_TIMER_EN builds the timer FSM, prescaler and
// counter. Without it CNT reads as zero and CNT writes are dropped.
module perip_bridge #(
  parameter int DRAM_AW  = 16,
  parameter int SCAN_DIV = 20000,
  parameter int CNT_DIV  = 50000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        perip_addr,
  input  logic               perip_wen,
  input  logic [1:0]         perip_mask,
  input  logic [31:0]        perip_wdata,
  output logic [31:0]        perip_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [1:0]         dram_mask,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [15:0]        sw,
  output logic [15:0]        led,
  output logic [7:0]         seg_an,
  output logic [7:0]         seg_code
);

  localparam logic [31:0] DRAM_BASE = 32'h8010_0000;
  localparam logic [32:0] DRAM_END  = {1'b0, DRAM_BASE} + (33'd1 << (DRAM_AW + 2));
  localparam logic [31:0] SW_ADDR   = 32'h8020_0000;
  localparam logic [31:0] SEG_ADDR  = 32'h8020_0020;
  localparam logic [31:0] LED_ADDR  = 32'h8020_0040;
  localparam logic [31:0] CNT_ADDR  = 32'h8020_0050;
  localparam int          SCAN_W    = $clog2(SCAN_DIV + 1);

  if (SCAN_DIV < 1 || CNT_DIV < 1 || DRAM_AW < 1 || DRAM_AW > 29) begin : g_bad_param
    $error("perip_bridge: parameter out of range");
  end

  // ---------------- address decode ----------------
  logic dram_hit, sw_sel, seg_sel, led_sel, cnt_sel;
  assign dram_hit = (perip_addr >= DRAM_BASE) && ({1'b0, perip_addr} < DRAM_END);
  // I/O registers decode on the word address so byte/half lanes hit them too.
  assign sw_sel   = perip_addr[31:2] == SW_ADDR[31:2];
  assign seg_sel  = perip_addr[31:2] == SEG_ADDR[31:2];
  assign led_sel  = perip_addr[31:2] == LED_ADDR[31:2];
  assign cnt_sel  = perip_addr[31:2] == CNT_ADDR[31:2];

  assign dram_addr  = perip_addr[DRAM_AW+1:2];
  assign dram_wen   = perip_wen & dram_hit;
  assign dram_mask  = perip_mask;
  assign dram_wdata = perip_wdata;

  // ---------------- store lane merge ----------------
  // Store data is LSB-aligned, so it is replicated across the word and the
  // lane enables pick which copy lands in the register.
  logic [3:0]  lane_en;
  logic [31:0] lane_data, bit_en;
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    lane_en   = 4'b1111;
    lane_data = perip_wdata;
    case (perip_mask)
      2'b00: begin
        lane_en   = 4'b0001 << perip_addr[1:0];
        lane_data = {4{perip_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = perip_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{perip_wdata[15:0]}};
      end
      default: ;
    endcase
  end
  assign bit_en = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};

  logic [15:0] led_q, led_d;
  logic [31:0] seg_reg_q, seg_reg_d;
  assign led_d     = (led_q & ~bit_en[15:0]) | (lane_data[15:0] & bit_en[15:0]);
  assign seg_reg_d = (seg_reg_q & ~bit_en) | (lane_data & bit_en);

  logic [15:0] sw_meta_q, sw_s_q;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    if (cpu_rst) begin
      led_q     <= '0;
      seg_reg_q <= '0;
      sw_meta_q <= '0;
      sw_s_q    <= '0;
    end else begin
      if (perip_wen && led_sel) led_q <= led_d;
      if (perip_wen && seg_sel) seg_reg_q <= seg_reg_d;
      sw_meta_q <= sw;
      sw_s_q    <= sw_meta_q;
    end
  end
  assign led = led_q;

  // ---------------- 7-segment scan ----------------
  function automatic logic [7:0] hex_pattern(input logic [3:0] nib);
    case (nib)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  logic [SCAN_W-1:0] scan_div_q;
  logic [2:0]        digit_q;
  logic              slot_load_q;
  logic [7:0]        seg_an_q, seg_code_q;
  logic              scan_wrap;
  assign scan_wrap = scan_div_q == SCAN_W'(SCAN_DIV - 1);

  // Anode and code load together only at the start of a slot, so a SEG
  // write never changes the digit currently lit; it shows on the next slot.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      scan_div_q  <= '0;
      digit_q     <= '0;
      slot_load_q <= 1'b0;
      seg_an_q    <= 8'hFE;
      seg_code_q  <= 8'hC0;
    end else begin
      slot_load_q <= scan_wrap;
      if (scan_wrap) begin
        scan_div_q <= '0;
        digit_q    <= digit_q + 3'd1;
      end else begin
        scan_div_q <= scan_div_q + SCAN_W'(1);
      end
      if (slot_load_q) begin
        seg_an_q   <= ~(8'd1 << digit_q);
        seg_code_q <= hex_pattern(seg_reg_q[{digit_q, 2'b00} +: 4]);
      end
    end
  end
  assign seg_an   = seg_an_q;
  assign seg_code = seg_code_q;

  // ---------------- millisecond timer ----------------
  logic [31:0] cnt_rd;
`ifdef PERIP_TIMER_EN
  localparam int PRE_W = $clog2(CNT_DIV + 1);
  typedef enum logic {T_IDLE = 1'b0, T_RUN = 1'b1} timer_state_e;

  timer_state_e     state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             cnt_word_wr;
  // Only full-word stores (mask 10 or 11) are timer commands.
  assign cnt_word_wr = perip_wen && cnt_sel && perip_mask[1];

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    if (cnt_word_wr && perip_wdata == 32'h8000_0000) begin
      state_d = T_RUN;
      pre_d   = '0;
      cnt_d   = '0;
    end else if (cnt_word_wr && perip_wdata == 32'hFFFF_FFFF) begin
      state_d = T_IDLE;
    end else if (state_q == T_RUN) begin
      if (pre_q == PRE_W'(CNT_DIV - 1)) begin
        pre_d = '0;
        cnt_d = cnt_q + 32'd1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= T_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end
  assign cnt_rd = cnt_q;
`else
  assign cnt_rd = 32'h0;
`endif

  // ---------------- read mux ----------------
  always_comb begin
    perip_rdata = 32'h0;
    if (dram_hit)     perip_rdata = dram_rdata;
    else if (sw_sel)  perip_rdata = {16'h0, sw_s_q};
    else if (seg_sel) perip_rdata = seg_reg_q;
    else if (led_sel) perip_rdata = {16'h0, led_q};
    else if (cnt_sel) perip_rdata = cnt_rd;
  end

endmodule

// File: tb/tb_perip_bridge.sv
// Self-checking bench for perip_bridge with SCAN_DIV=4 and CNT_DIV=10.
// The reference model tracks register contents per byte lane, and derives
// scan slot and timer count from the number of clock edges since reset.
module tb_perip_bridge;
  localparam int DRAM_AW  = 16;
  localparam int SCAN_DIV = 4;
  localparam int CNT_DIV  = 10;
`ifdef PERIP_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif
  localparam logic [31:0] SW_A  = 32'h8020_0000;
  localparam logic [31:0] SEG_A = 32'h8020_0020;
  localparam logic [31:0] LED_A = 32'h8020_0040;
  localparam logic [31:0] CNT_A = 32'h8020_0050;

  logic               cpu_clk = 1'b0;
  logic               cpu_rst = 1'b1;
  logic [31:0]        perip_addr = '0;
  logic               perip_wen = 1'b0;
  logic [1:0]         perip_mask = 2'b10;
  logic [31:0]        perip_wdata = '0;
  logic [31:0]        perip_rdata;
  logic [DRAM_AW-1:0] dram_addr;
  logic               dram_wen;
  logic [1:0]         dram_mask;
  logic [31:0]        dram_wdata;
  logic [31:0]        dram_rdata = '0;
  logic [15:0]        sw = '0;
  logic [15:0]        led;
  logic [7:0]         seg_an, seg_code;

  perip_bridge #(.DRAM_AW(DRAM_AW), .SCAN_DIV(SCAN_DIV), .CNT_DIV(CNT_DIV)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .perip_addr(perip_addr), .perip_wen(perip_wen), .perip_mask(perip_mask),
    .perip_wdata(perip_wdata), .perip_rdata(perip_rdata),
    .dram_addr(dram_addr), .dram_wen(dram_wen), .dram_mask(dram_mask),
    .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .sw(sw), .led(led), .seg_an(seg_an), .seg_code(seg_code)
  );

  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;  // rising edges since reset was released
  always @(posedge cpu_clk or posedge cpu_rst)
    if (cpu_rst) cyc <= 0; else cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [15:0] led_m;
  logic [31:0] seg_m, seg_prev;
  int          seg_edge, seg_prev_edge;
  bit          t_run;
  int          t_start;
  logic [31:0] t_hold;
  logic [15:0] sw_old;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[n];
  endfunction

  function automatic bit in_dram(input logic [31:0] a);
    return a >= 32'h8010_0000 && a < 32'h8014_0000;
  endfunction

  function automatic bit same_word(input logic [31:0] a, input logic [31:0] reg_a);
    return (a >> 2) == (reg_a >> 2);
  endfunction

  function automatic logic [31:0] cnt_exp();
    if (!TIMER_EN) return 32'h0;
    if (t_run) return 32'((cyc - t_start) / CNT_DIV);
    return t_hold;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (in_dram(a))            return dram_rdata;
    if (same_word(a, SW_A))    return {16'h0, sw};
    if (same_word(a, SEG_A))   return seg_m;
    if (same_word(a, LED_A))   return {16'h0, led_m};
    if (same_word(a, CNT_A))   return cnt_exp();
    return 32'h0;
  endfunction

  // Place the low 1/2/4 data bytes starting at the lane the address selects.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [31:0] d, input logic [1:0] m);
    int base, nbytes;
    logic [31:0] r;
    r = old;
    if (m == 2'b00)      begin base = int'(a[1:0]); nbytes = 1; end
    else if (m == 2'b01) begin base = a[1] ? 2 : 0; nbytes = 2; end
    else                 begin base = 0;            nbytes = 4; end
    for (int i = 0; i < nbytes; i++) r[8*(base+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    led_m = '0; seg_m = '0; seg_prev = '0;
    seg_edge = -1; seg_prev_edge = -1;
    t_run = 1'b0; t_start = 0; t_hold = '0;
  endtask

  // edge_i: index of the rising edge on which the store takes effect.
  task automatic model_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] m, input int edge_i);
    logic [31:0] t;
    if (same_word(a, LED_A)) begin
      t = merge({16'h0, led_m}, a, d, m);
      led_m = t[15:0];
    end
    if (same_word(a, SEG_A)) begin
      seg_prev = seg_m; seg_prev_edge = seg_edge;
      seg_m = merge(seg_m, a, d, m); seg_edge = edge_i;
    end
    if (TIMER_EN && same_word(a, CNT_A) && m[1]) begin
      if (d == 32'h8000_0000) begin
        t_run = 1'b1; t_start = edge_i;
      end else if (d == 32'hFFFF_FFFF) begin
        if (t_run) t_hold = 32'((edge_i - 1 - t_start) / CNT_DIV);
        t_run = 1'b0;
      end
    end
  endtask

  // ---------------- bus drivers ----------------
  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
    @(negedge cpu_clk);
    perip_addr = a; perip_wdata = d; perip_mask = m; perip_wen = 1'b1;
    model_store(a, d, m, cyc + 1);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
    drive_store(a, d, m);
    @(negedge cpu_clk);
    perip_wen = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    @(negedge cpu_clk);
    perip_wen = 1'b0; perip_addr = a; dram_rdata = $urandom;
    #1 d = perip_rdata;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cpu_rst = 1'b1; perip_addr = CNT_A;
    repeat (2) @(negedge cpu_clk);
    #1;
    checks++; if (led !== 16'h0)      begin failures++; $display("FAIL reset_led got=%h exp=0000", led); end
    checks++; if (seg_an !== 8'hFE)   begin failures++; $display("FAIL reset_seg_an got=%h exp=fe", seg_an); end
    checks++; if (seg_code !== 8'hC0) begin failures++; $display("FAIL reset_seg_code got=%h exp=c0", seg_code); end
    checks++; if (perip_rdata !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", perip_rdata); end
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sw();
    logic [15:0] nv;
    for (int i = 0; i < 4; i++) begin
      nv = (i == 0) ? 16'hA5C3 : 16'($urandom);
      @(negedge cpu_clk);
      sw = nv; perip_addr = SW_A; perip_wen = 1'b0;
      @(negedge cpu_clk); #1;
      checks++;
      if (perip_rdata !== {16'h0, sw_old}) begin
        failures++; $display("FAIL sw_after_1clk got=%h exp=%h", perip_rdata, {16'h0, sw_old});
      end
      @(negedge cpu_clk); #1;
      checks++;
      if (perip_rdata !== {16'h0, nv}) begin
        failures++; $display("FAIL sw_after_2clk got=%h exp=%h", perip_rdata, {16'h0, nv});
      end
      sw_old = nv;
    end
  endtask

  task automatic test_reg_lanes();
    logic [31:0] a, d, r, e;
    logic [1:0]  m;
    store(LED_A, 32'h0000_00FF, 2'b10);
    store(LED_A + 32'd1, 32'h0000_0012, 2'b00);
    #1;
    checks++; if (led !== 16'h12FF) begin failures++; $display("FAIL led_byte1 got=%h exp=12ff", led); end
    for (int i = 0; i < 16; i++) begin
      m = 2'($urandom_range(0, 3));
      d = $urandom;
      a = (($urandom & 1) != 0) ? SEG_A : LED_A;
      a = a | 32'($urandom_range(0, 3));
      store(a, d, m);
      #1;
      checks++; if (led !== led_m) begin failures++; $display("FAIL lane_led got=%h exp=%h", led, led_m); end
      load(a & ~32'h3, r);
      e = exp_read(a & ~32'h3);
      checks++; if (r !== e) begin failures++; $display("FAIL lane_read a=%h got=%h exp=%h", a, r, e); end
    end
  endtask

  task automatic test_dram();
    logic [31:0] a, d, e;
    logic [1:0]  m;
    bit          hit;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: a = 32'h8010_0010;
        1: a = 32'h8013_FFFC;
        2: a = 32'h8014_0000;
        3: a = 32'h800F_FFFC;
        default: a = 32'h8010_0000 + ($urandom & 32'h0003_FFFF);
      endcase
      d = $urandom;
      m = (i < 4) ? 2'b10 : 2'($urandom_range(0, 3));
      hit = in_dram(a);
      @(negedge cpu_clk);
      perip_addr = a; perip_wdata = d; perip_mask = m; perip_wen = 1'b1;
      model_store(a, d, m, cyc + 1);
      #1;
      checks++; if (dram_wen !== hit) begin failures++; $display("FAIL dram_wen a=%h got=%b exp=%b", a, dram_wen, hit); end
      if (hit) begin
        checks++;
        if (dram_addr !== 16'((a - 32'h8010_0000) / 4)) begin
          failures++; $display("FAIL dram_addr a=%h got=%h exp=%h", a, dram_addr, 16'((a - 32'h8010_0000) / 4));
        end
      end
      checks++; if (dram_mask !== m)  begin failures++; $display("FAIL dram_mask got=%b exp=%b", dram_mask, m); end
      checks++; if (dram_wdata !== d) begin failures++; $display("FAIL dram_wdata got=%h exp=%h", dram_wdata, d); end
      @(negedge cpu_clk);
      perip_wen = 1'b0; dram_rdata = $urandom;
      #1;
      e = exp_read(a);
      checks++; if (perip_rdata !== e) begin failures++; $display("FAIL dram_read a=%h got=%h exp=%h", a, perip_rdata, e); end
      checks++; if (led !== led_m) begin failures++; $display("FAIL dram_led_side got=%h exp=%h", led, led_m); end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] a, r;
    logic [7:0]  an0;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: a = 32'h8030_0000;
        1: a = 32'h8020_0004;
        2: a = 32'h0000_0000;
        3: a = 32'h8020_0060;
        default: a = 32'h9000_0000 | ($urandom & 32'h0FFF_FFFC);
      endcase
      load(a, r);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL unmapped_read a=%h got=%h exp=0", a, r); end
      @(negedge cpu_clk);
      an0 = seg_an;
      perip_addr = a; perip_wdata = $urandom; perip_mask = 2'b10; perip_wen = 1'b1;
      #1;
      checks++; if (dram_wen !== 1'b0) begin failures++; $display("FAIL unmapped_dram_wen a=%h got=%b exp=0", a, dram_wen); end
      @(negedge cpu_clk);
      perip_wen = 1'b0;
      #1;
      checks++; if (led !== led_m) begin failures++; $display("FAIL unmapped_led got=%h exp=%h", led, led_m); end
      load(SEG_A, r);
      checks++; if (r !== seg_m) begin failures++; $display("FAIL unmapped_seg got=%h exp=%h", r, seg_m); end
    end
  endtask

  task automatic test_scan();
    int k, dig, ld;
    logic [7:0] e_an, e_code;
    bit         chk_code;
    store(SEG_A, 32'h8765_4321, 2'b10);
    perip_addr = SEG_A;
    for (int i = 0; i < 56; i++) begin
      @(negedge cpu_clk);
      perip_wen = 1'b0;
      if (i == 25) begin
        // Mid-slot rewrite: current digit must keep its code until the next slot.
        perip_wdata = $urandom; perip_mask = 2'b10; perip_wen = 1'b1;
        model_store(SEG_A, perip_wdata, 2'b10, cyc + 1);
      end
      #1;
      k   = (cyc == 0) ? 0 : (cyc - 1) / SCAN_DIV;
      dig = k % 8;
      ld  = k * SCAN_DIV + 1;
      e_an = ~(8'd1 << dig);
      chk_code = 1'b1;
      if (k == 0)                  e_code = 8'hC0;
      else if (seg_edge < ld)      e_code = hex7(4'((seg_m >> (4 * dig)) & 32'hF));
      else if (seg_prev_edge < ld) e_code = hex7(4'((seg_prev >> (4 * dig)) & 32'hF));
      else begin                   e_code = 8'h00; chk_code = 1'b0; end
      checks++; if (seg_an !== e_an) begin failures++; $display("FAIL scan_an cyc=%0d got=%h exp=%h", cyc, seg_an, e_an); end
      if (chk_code) begin
        checks++;
        if (seg_code !== e_code) begin
          failures++; $display("FAIL scan_code cyc=%0d got=%h exp=%h", cyc, seg_code, e_code);
        end
      end
    end
  endtask

  task automatic test_timer();
    logic [31:0] r, e;
    store(CNT_A, 32'h8000_0000, 2'b10);
    repeat (105) @(negedge cpu_clk);
    store(CNT_A, 32'hFFFF_FFFF, 2'b10);
    load(CNT_A, r); e = cnt_exp();
    checks++; if (r !== e) begin failures++; $display("FAIL cnt_after_stop got=%0d exp=%0d", r, e); end
    repeat (50) @(negedge cpu_clk);
    load(CNT_A, r); e = cnt_exp();
    checks++; if (r !== e) begin failures++; $display("FAIL cnt_held got=%0d exp=%0d", r, e); end
    // Running reads, a restart while running, and ignored writes.
    store(CNT_A, 32'h8000_0000, 2'b10);
    repeat ($urandom_range(20, 40)) @(negedge cpu_clk);
    store(CNT_A, 32'h8000_0000, 2'b10);
    store(CNT_A, 32'h8000_0000, 2'b00);
    store(CNT_A, 32'h1234_5678, 2'b11);
    store(CNT_A, 32'hFFFF_FFFF, 2'b01);
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge cpu_clk);
      load(CNT_A, r); e = cnt_exp();
      checks++; if (r !== e) begin failures++; $display("FAIL cnt_running cyc=%0d got=%0d exp=%0d", cyc, r, e); end
    end
    store(CNT_A, 32'hFFFF_FFFF, 2'b10);
    load(CNT_A, r); e = cnt_exp();
    checks++; if (r !== e) begin failures++; $display("FAIL cnt_stop2 got=%0d exp=%0d", r, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, r;
    for (int i = 0; i < 10; i++) begin
      a = (($urandom & 1) != 0) ? SEG_A : LED_A;
      drive_store(a | 32'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)));
    end
    @(negedge cpu_clk);
    perip_wen = 1'b0;
    #1;
    checks++; if (led !== led_m) begin failures++; $display("FAIL b2b_led got=%h exp=%h", led, led_m); end
    load(SEG_A, r);
    checks++; if (r !== seg_m) begin failures++; $display("FAIL b2b_seg got=%h exp=%h", r, seg_m); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] r;
    store(CNT_A, 32'h8000_0000, 2'b10);
    store(LED_A, $urandom | 32'h1, 2'b10);
    repeat ($urandom_range(13, 40)) @(negedge cpu_clk);
    perip_addr = CNT_A;
    #2 cpu_rst = 1'b1;
    #1;
    checks++; if (led !== 16'h0)      begin failures++; $display("FAIL midrst_led got=%h exp=0000", led); end
    checks++; if (seg_an !== 8'hFE)   begin failures++; $display("FAIL midrst_seg_an got=%h exp=fe", seg_an); end
    checks++; if (seg_code !== 8'hC0) begin failures++; $display("FAIL midrst_seg_code got=%h exp=c0", seg_code); end
    checks++; if (perip_rdata !== 32'h0) begin failures++; $display("FAIL midrst_cnt got=%h exp=0", perip_rdata); end
    checks++; if (dram_wen !== 1'b0)  begin failures++; $display("FAIL midrst_dram_wen got=%b exp=0", dram_wen); end
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    model_reset();
    repeat (12) @(negedge cpu_clk);
    load(CNT_A, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL postrst_cnt_stopped got=%h exp=0", r); end
  endtask

  initial begin
    sw_old = 16'h0;
    model_reset();
    test_reset();
    test_sw();
    test_reg_lanes();
    test_dram();
    test_unmapped();
    test_scan();
    test_timer();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog bench did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
